// File: rtl/seq_mem_8x8b_1r1w_rf_pw.sv
// Purpose: 8-entry x 8-bit scratch register file, one combinational read port, one nibble-masked write port.
// Latency: write commits on the rising clk edge (visible next cycle); read is combinational, 0 cycles, no write bypass.
// Backpressure: none; a write is accepted every cycle, and write_nibble_en = 2'b00 is an idle cycle.
module seq_mem_8x8b_1r1w_rf_pw (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] read_addr,
    output logic [7:0] read_data,
    input  logic [1:0] write_nibble_en,
    input  logic [2:0] write_addr,
    input  logic [7:0] write_data
);

    // Whole array held as one packed vector so next-state can be built by a single copy plus a targeted merge.
    logic [7:0][7:0] mem_q;
    logic [7:0][7:0] mem_d;

    // Next-state: every entry holds, except the enabled nibbles of the addressed entry.
    always_comb begin
        mem_d = mem_q;
        if (write_nibble_en[0]) begin
            mem_d[write_addr][3:0] = write_data[3:0];
        end
        if (write_nibble_en[1]) begin
            mem_d[write_addr][7:4] = write_data[7:4];
        end
    end

    // Array state: reset clears all entries at once and wins over any write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // The read mux looks only at stored state, so a same-address write shows up only after the edge.
    assign read_data = mem_q[read_addr];

endmodule

// File: tb/tb_seq_mem_8x8b_1r1w_rf_pw.sv
module tb_seq_mem_8x8b_1r1w_rf_pw;

    logic       clk;
    logic       reset;
    logic [2:0] read_addr;
    logic [7:0] read_data;
    logic [1:0] write_nibble_en;
    logic [2:0] write_addr;
    logic [7:0] write_data;

    int tests_run;
    int tests_failed;

    logic [7:0] model [8];
    logic [7:0] fill_vals [8];

    seq_mem_8x8b_1r1w_rf_pw dut (
        .clk             (clk),
        .reset           (reset),
        .read_addr       (read_addr),
        .read_data       (read_data),
        .write_nibble_en (write_nibble_en),
        .write_addr      (write_addr),
        .write_data      (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    // Present one write, let it commit on the next edge, then idle the write port.
    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [1:0] en);
        write_addr      = a;
        write_data      = d;
        write_nibble_en = en;
        @(posedge clk);
        #1;
        write_nibble_en = 2'b00;
    endtask

    // Combinational read: settle briefly, compare, no clock edge.
    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        read_addr = a;
        #1;
        check(tag, read_data, exp);
    endtask

    initial begin
        logic [2:0] ra;
        logic [2:0] wa;
        logic [1:0] we;
        logic [7:0] wd;

        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        read_addr       = 3'd0;
        write_nibble_en = 2'b00;
        write_addr      = 3'd0;
        write_data      = 8'h00;
        fill_vals[0] = 8'h01; fill_vals[1] = 8'h23; fill_vals[2] = 8'h45; fill_vals[3] = 8'h67;
        fill_vals[4] = 8'h89; fill_vals[5] = 8'hab; fill_vals[6] = 8'hcd; fill_vals[7] = 8'hef;

        // Reset state
        #2;
        rd(3'd5, 8'h00, "in_reset_a5");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "post_reset");

        for (int i = 0; i < 8; i++) wr(i[2:0], 8'h00, 2'b11);
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "zero_write");

        // Write 0xab to addr 0: old value until the edge, new value after
        read_addr       = 3'd0;
        write_addr      = 3'd0;
        write_data      = 8'hab;
        write_nibble_en = 2'b11;
        #1;
        check("same_cycle_old", read_data, 8'h00);
        @(posedge clk);
        #1;
        write_nibble_en = 2'b00;
        check("next_cycle_new", read_data, 8'hab);

        wr(3'd1, 8'hcd, 2'b11);
        rd(3'd1, 8'hcd, "a1_cd");
        rd(3'd0, 8'hab, "a0_kept_ab");
        wr(3'd1, 8'hef, 2'b11);
        rd(3'd1, 8'hef, "a1_overwrite_ef");

        // Fill, then read every entry while addr 0 is written with 0xff every cycle
        for (int i = 0; i < 8; i++) wr(i[2:0], fill_vals[i], 2'b11);
        write_addr      = 3'd0;
        write_data      = 8'hff;
        write_nibble_en = 2'b11;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            read_addr = i[2:0];
            #1;
            check("fill_read", read_data, (i == 0) ? 8'hff : fill_vals[i]);
            @(posedge clk);
            #1;
        end
        write_nibble_en = 2'b00;

        // Nibble-masked writes on every address
        for (int a = 0; a < 8; a++) begin
            wr(a[2:0], 8'hff, 2'b11);
            rd(a[2:0], 8'hff, "part_ff");
            wr(a[2:0], 8'hab, 2'b01);
            rd(a[2:0], 8'hfb, "part_lo_fb");
            wr(a[2:0], 8'hab, 2'b10);
            rd(a[2:0], 8'hab, "part_hi_ab");
            wr(a[2:0], 8'h00, 2'b00);
            rd(a[2:0], 8'hab, "part_en00_hold");
        end

        // Mid-sequence reset, asserted away from an edge, with a write in flight
        wr(3'd3, 8'h5a, 2'b11);
        rd(3'd3, 8'h5a, "pre_reset_a3");
        write_addr      = 3'd3;
        write_data      = 8'hc3;
        write_nibble_en = 2'b11;
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_a3", read_data, 8'h00);
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "mid_reset_all");
        @(posedge clk);
        #1;
        rd(3'd3, 8'h00, "write_during_reset");
        write_nibble_en = 2'b00;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "after_reset");

        // Random traffic against a golden model
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        for (int c = 0; c < 40; c++) begin
            ra = 3'($urandom_range(0, 7));
            wa = 3'($urandom_range(0, 7));
            we = 2'($urandom_range(0, 3));
            wd = 8'($urandom_range(0, 255));
            read_addr       = ra;
            write_addr      = wa;
            write_nibble_en = we;
            write_data      = wd;
            #1;
            check("random", read_data, model[ra]);
            @(posedge clk);
            if (we[0]) model[wa][3:0] = wd[3:0];
            if (we[1]) model[wa][7:4] = wd[7:4];
            #1;
        end
        write_nibble_en = 2'b00;
        for (int i = 0; i < 8; i++) rd(i[2:0], model[i], "random_final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
